cb_prog_loader: RTL

- Serial configuration master for connection-block (CB) programming chains, clocked on prog_clk.
- Latches a WIDTH-bit bitstream and shifts it into a CB chain over prog_in/prog_en, LSB first.
- Optionally performs a second pass to read back the chain's prog_out and report mismatches. This replaces hand-written bench tasks.
- Sits between the configuration controller and each CB instance's prog_in/prog_en/prog_out pins.

---
 rtl/cb_prog_loader.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/cb_prog_loader.sv
// Serial configuration master for a connection-block programming chain.
// A latched config word is shifted into the chain LSB first. An optional
// second pass re-shifts the same word while comparing the chain's prog_out
// against the shadow copy. Because the second pass shifts identical data,
// the chain contents end unchanged.
module cb_prog_loader #(
   parameter int WIDTH = 69,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic             prog_clk,
   input  logic             prog_rst_n,
   input  logic             start,
   input  logic             verify_en,
   input  logic             abort,
   input  logic [WIDTH-1:0] bitstream,
   input  logic             prog_out,
   output logic             prog_in,
   output logic             prog_en,
   output logic             busy,
   output logic             done,
   output logic             verify_ok,
   output logic [CW-1:0]    err_cnt,
   output logic [CW-1:0]    first_err_idx
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_VERIFY,
      S_FINISH
   } state_t;

   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
   localparam logic [CW-1:0] ERR_MAX  = CW'(WIDTH);

   state_t             state_q, state_d;
   logic [CW-1:0]      k_q, k_d;
   logic [WIDTH-1:0]   shadow_q, shadow_d;
   logic               ver_q, ver_d;
   logic               prog_in_q, prog_in_d;
   logic               prog_en_q, prog_en_d;
   logic               done_q, done_d;
   logic               verify_ok_q, verify_ok_d;
   logic [CW-1:0]      err_cnt_q, err_cnt_d;
   logic [CW-1:0]      first_err_idx_q, first_err_idx_d;
   logic [CW-1:0]      k_inc;

   assign k_inc = k_q + 1'b1;

   // Next-state and registered-output logic. prog_in/prog_en are computed one
   // cycle ahead so that during pass cycle k the chain sees shadow[k].
   always_comb begin
      state_d         = state_q;
      k_d             = k_q;
      shadow_d        = shadow_q;
      ver_d           = ver_q;
      prog_in_d       = 1'b0;
      prog_en_d       = 1'b0;
      done_d          = 1'b0;
      verify_ok_d     = verify_ok_q;
      err_cnt_d       = err_cnt_q;
      first_err_idx_d = first_err_idx_q;
      case (state_q)
         S_IDLE: begin
            // abort has priority over a coincident start
            if (start && !abort) begin
               shadow_d        = bitstream;
               ver_d           = verify_en;
               err_cnt_d       = '0;
               first_err_idx_d = '0;
               verify_ok_d     = 1'b0;
               k_d             = '0;
               prog_en_d       = 1'b1;
               prog_in_d       = bitstream[0];
               state_d         = S_LOAD;
            end
         end
         S_LOAD: begin
            if (abort) begin
               verify_ok_d = 1'b0;
               k_d         = '0;
               state_d     = S_IDLE;
            end else if (k_q == LAST_IDX) begin
               k_d = '0;
               if (ver_q) begin
                  // back-to-back into the readback pass, no enable gap
                  prog_en_d = 1'b1;
                  prog_in_d = shadow_q[0];
                  state_d   = S_VERIFY;
               end else begin
                  done_d      = 1'b1;
                  verify_ok_d = 1'b0;
                  state_d     = S_FINISH;
               end
            end else begin
               k_d       = k_inc;
               prog_en_d = 1'b1;
               prog_in_d = shadow_q[k_inc];
            end
         end
         S_VERIFY: begin
            if (abort) begin
               verify_ok_d = 1'b0;
               k_d         = '0;
               state_d     = S_IDLE;
            end else begin
               // err_cnt never wraps, so zero means no mismatch seen yet
               if (prog_out != shadow_q[k_q]) begin
                  if (err_cnt_q == '0) begin
                     first_err_idx_d = k_q;
                  end
                  if (err_cnt_q != ERR_MAX) begin
                     err_cnt_d = err_cnt_q + 1'b1;
                  end
               end
               if (k_q == LAST_IDX) begin
                  k_d         = '0;
                  done_d      = 1'b1;
                  verify_ok_d = (err_cnt_d == '0);
                  state_d     = S_FINISH;
               end else begin
                  k_d       = k_inc;
                  prog_en_d = 1'b1;
                  prog_in_d = shadow_q[k_inc];
               end
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge prog_clk) begin
      if (!prog_rst_n) begin
         state_q         <= S_IDLE;
         k_q             <= '0;
         shadow_q        <= '0;
         ver_q           <= 1'b0;
         prog_in_q       <= 1'b0;
         prog_en_q       <= 1'b0;
         done_q          <= 1'b0;
         verify_ok_q     <= 1'b0;
         err_cnt_q       <= '0;
         first_err_idx_q <= '0;
      end else begin
         state_q         <= state_d;
         k_q             <= k_d;
         shadow_q        <= shadow_d;
         ver_q           <= ver_d;
         prog_in_q       <= prog_in_d;
         prog_en_q       <= prog_en_d;
         done_q          <= done_d;
         verify_ok_q     <= verify_ok_d;
         err_cnt_q       <= err_cnt_d;
         first_err_idx_q <= first_err_idx_d;
      end
   end

   assign prog_in       = prog_in_q;
   assign prog_en       = prog_en_q;
   assign busy          = (state_q == S_LOAD) || (state_q == S_VERIFY);
   assign done          = done_q;
   assign verify_ok     = verify_ok_q;
   assign err_cnt       = err_cnt_q;
   assign first_err_idx = first_err_idx_q;

endmodule
